// File: rtl/udc_config_sequencer_if.sv
// rtl/udc_config_sequencer_if.sv - host and counter-bus signal bundle for udc_config_sequencer
//
// Host side : req, plr, ulr, llr, ccr (job request and register values)
//             busy, done, fail, fail_code (job status)
// Counter   : ncs, nwr, nrd, a1, a0, dout, dout_en (bus master outputs)
//             din (read data), start_out, ec_in, err_in (run control/status)
// master modport is the sequencer's view, slave modport the host/counter view.
interface udc_config_sequencer_if;
  logic       req;
  logic [7:0] plr;
  logic [7:0] ulr;
  logic [7:0] llr;
  logic [7:0] ccr;
  logic       busy;
  logic       done;
  logic       fail;
  logic [1:0] fail_code;
  logic       ncs;
  logic       nwr;
  logic       nrd;
  logic       a1;
  logic       a0;
  logic [7:0] dout;
  logic       dout_en;
  logic [7:0] din;
  logic       start_out;
  logic       ec_in;
  logic       err_in;

  modport master (
    input  req, plr, ulr, llr, ccr, din, ec_in, err_in,
    output busy, done, fail, fail_code,
    output ncs, nwr, nrd, a1, a0, dout, dout_en, start_out
  );

  modport slave (
    output req, plr, ulr, llr, ccr, din, ec_in, err_in,
    input  busy, done, fail, fail_code,
    input  ncs, nwr, nrd, a1, a0, dout, dout_en, start_out
  );
endinterface

// File: rtl/udc_config_sequencer.sv
// rtl/udc_config_sequencer.sv - configures, verifies and starts one up/down counter
//
// clk   : system clock, all state on posedge
// reset : asynchronous active-low reset; releases the counter bus at once
// bus   : udc_config_sequencer_if.master
//         host    - req/plr/ulr/llr/ccr in; busy/done/fail/fail_code out
//         counter - ncs/nwr/nrd/a1/a0/dout/dout_en/start_out out; din/ec_in/err_in in
// VERIFY: 1 reads back all four registers after writing them
// TO_W  : end-cycle timeout counter width (>= 2); fires after 2^TO_W-1 cycles
module udc_config_sequencer #(
  parameter bit VERIFY = 1'b1,
  parameter int TO_W   = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  udc_config_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_W_SETUP,
    S_W_STROBE,
    S_W_HOLD,
    S_R_SETUP,
    S_R_SAMPLE,
    S_R_END,
    S_ARM,
    S_START,
    S_WAIT_EC,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_CFG  = 2'b01;
  localparam logic [1:0] FC_RB   = 2'b10;
  localparam logic [1:0] FC_TO   = 2'b11;

  // Last WAIT_EC cycle: the counter steps to all-ones at the end of it.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_t          state, state_nxt;
  logic [1:0]      idx, idx_nxt;          // register index: 0 PLR, 1 ULR, 2 LLR, 3 CCR
  logic [7:0]      cfg [4];               // latched job values, indexed like the counter
  logic            load;
  logic            mism, mism_nxt;        // sticky read-back mismatch
  logic [TO_W-1:0] to_cnt, to_nxt;
  logic [1:0]      code_q, code_nxt;

  logic            ncs_q, nwr_q, nrd_q, den_q, start_q, busy_q, done_q, fail_q;
  logic [1:0]      addr_q;
  logic [7:0]      dout_q;
  logic            ncs_nxt, nwr_nxt, nrd_nxt, den_nxt, start_nxt, busy_nxt, done_nxt, fail_nxt;
  logic [1:0]      addr_nxt;
  logic [7:0]      dout_nxt;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    mism_nxt  = mism;
    to_nxt    = to_cnt;
    code_nxt  = code_q;

    case (state)
      S_IDLE: begin
        if (bus.req) begin
          load      = 1'b1;
          mism_nxt  = 1'b0;
          code_nxt  = FC_NONE;
          idx_nxt   = 2'd0;
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((cfg[2] <= cfg[0]) && (cfg[0] <= cfg[1])) begin
          state_nxt = S_W_SETUP;
        end else begin
          code_nxt  = FC_CFG;
          state_nxt = S_FAIL;
        end
      end
      S_W_SETUP:  state_nxt = S_W_STROBE;
      S_W_STROBE: state_nxt = S_W_HOLD;
      S_W_HOLD: begin
        if (idx == 2'd3) begin
          idx_nxt   = 2'd0;
          state_nxt = VERIFY ? S_R_SETUP : S_ARM;
        end else begin
          idx_nxt   = idx + 2'd1;
          state_nxt = S_W_SETUP;
        end
      end
      S_R_SETUP:  state_nxt = S_R_SAMPLE;
      S_R_SAMPLE: begin
        if (bus.din != cfg[idx]) mism_nxt = 1'b1;
        state_nxt = S_R_END;
      end
      S_R_END: begin
        if (idx == 2'd3) begin
          idx_nxt = 2'd0;
          if (mism) begin
            code_nxt  = FC_RB;
            state_nxt = S_FAIL;
          end else begin
            state_nxt = S_ARM;
          end
        end else begin
          idx_nxt   = idx + 2'd1;
          state_nxt = S_R_SETUP;
        end
      end
      S_ARM: begin
        if (bus.err_in) begin
          code_nxt  = FC_CFG;
          state_nxt = S_FAIL;
        end else begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        to_nxt    = '0;
        state_nxt = S_WAIT_EC;
      end
      S_WAIT_EC: begin
        to_nxt = to_cnt + 1'b1;
        // ec_in is checked first so it wins over a simultaneous timeout.
        if (bus.ec_in) begin
          state_nxt = S_DONE;
        end else if (to_cnt == TO_LAST) begin
          code_nxt  = FC_TO;
          state_nxt = S_FAIL;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_FAIL:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so the strobes
    // toggle cleanly on the clock edge and appear in the same cycle as the state.
    ncs_nxt   = 1'b1;
    nwr_nxt   = 1'b1;
    nrd_nxt   = 1'b1;
    den_nxt   = 1'b0;
    start_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    fail_nxt  = 1'b0;
    addr_nxt  = 2'd0;
    dout_nxt  = 8'd0;

    case (state_nxt)
      S_CHECK: busy_nxt = 1'b1;
      S_W_SETUP, S_W_STROBE, S_W_HOLD: begin
        ncs_nxt  = 1'b0;
        busy_nxt = 1'b1;
        addr_nxt = idx_nxt;
        dout_nxt = cfg[idx_nxt];
        den_nxt  = 1'b1;
        nwr_nxt  = (state_nxt != S_W_STROBE);
      end
      S_R_SETUP, S_R_SAMPLE, S_R_END: begin
        ncs_nxt  = 1'b0;
        busy_nxt = 1'b1;
        addr_nxt = idx_nxt;
        nrd_nxt  = (state_nxt == S_R_END);
      end
      S_ARM, S_WAIT_EC: begin
        ncs_nxt  = 1'b0;
        busy_nxt = 1'b1;
      end
      S_START: begin
        ncs_nxt   = 1'b0;
        busy_nxt  = 1'b1;
        start_nxt = 1'b1;
      end
      S_DONE:  done_nxt = 1'b1;
      S_FAIL:  fail_nxt = 1'b1;
      default: busy_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      idx     <= 2'd0;
      mism    <= 1'b0;
      to_cnt  <= '0;
      code_q  <= FC_NONE;
      for (int i = 0; i < 4; i++) cfg[i] <= 8'd0;
      ncs_q   <= 1'b1;
      nwr_q   <= 1'b1;
      nrd_q   <= 1'b1;
      den_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      addr_q  <= 2'd0;
      dout_q  <= 8'd0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      mism    <= mism_nxt;
      to_cnt  <= to_nxt;
      code_q  <= code_nxt;
      if (load) begin
        cfg[0] <= bus.plr;
        cfg[1] <= bus.ulr;
        cfg[2] <= bus.llr;
        cfg[3] <= bus.ccr;
      end
      ncs_q   <= ncs_nxt;
      nwr_q   <= nwr_nxt;
      nrd_q   <= nrd_nxt;
      den_q   <= den_nxt;
      start_q <= start_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      fail_q  <= fail_nxt;
      addr_q  <= addr_nxt;
      dout_q  <= dout_nxt;
    end
  end

  assign bus.ncs       = ncs_q;
  assign bus.nwr       = nwr_q;
  assign bus.nrd       = nrd_q;
  assign bus.a1        = addr_q[1];
  assign bus.a0        = addr_q[0];
  assign bus.dout      = dout_q;
  assign bus.dout_en   = den_q;
  assign bus.start_out = start_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.fail_code = code_q;

endmodule

// File: tb/tb_udc_config_sequencer.sv
// tb/tb_udc_config_sequencer.sv - self-checking bench for udc_config_sequencer
module tb_udc_config_sequencer;
  localparam int TO_W = 4;
  localparam int TO   = (1 << TO_W) - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel;                 // 0: VERIFY=1 instance, 1: VERIFY=0 instance
  logic       req, ec_in, err_in;
  logic [7:0] plr, ulr, llr, ccr;
  logic [7:0] cnt_regs [4];        // counter peripheral registers
  logic       locked;              // counter running: writes are ignored
  int         corrupt;             // register read back with bit 0 flipped, 4 = none
  int         errors = 0;
  int         checks = 0;

  udc_config_sequencer_if bus_v ();
  udc_config_sequencer_if bus_n ();

  udc_config_sequencer #(.VERIFY(1'b1), .TO_W(TO_W)) dut_v (.clk(clk), .reset(reset), .bus(bus_v));
  udc_config_sequencer #(.VERIFY(1'b0), .TO_W(TO_W)) dut_n (.clk(clk), .reset(reset), .bus(bus_n));

  always #5 clk = ~clk;

  logic       o_ncs, o_nwr, o_nrd, o_den, o_start, o_busy, o_done, o_fail;
  logic [1:0] o_addr, o_code;
  logic [7:0] o_dout, din;

  assign o_ncs   = sel ? bus_n.ncs       : bus_v.ncs;
  assign o_nwr   = sel ? bus_n.nwr       : bus_v.nwr;
  assign o_nrd   = sel ? bus_n.nrd       : bus_v.nrd;
  assign o_den   = sel ? bus_n.dout_en   : bus_v.dout_en;
  assign o_start = sel ? bus_n.start_out : bus_v.start_out;
  assign o_busy  = sel ? bus_n.busy      : bus_v.busy;
  assign o_done  = sel ? bus_n.done      : bus_v.done;
  assign o_fail  = sel ? bus_n.fail      : bus_v.fail;
  assign o_addr  = sel ? {bus_n.a1, bus_n.a0} : {bus_v.a1, bus_v.a0};
  assign o_code  = sel ? bus_n.fail_code : bus_v.fail_code;
  assign o_dout  = sel ? bus_n.dout      : bus_v.dout;
  assign din     = (!o_nrd && !o_ncs) ?
                   (cnt_regs[o_addr] ^ ((corrupt == int'(o_addr)) ? 8'h01 : 8'h00)) : 8'h00;

  assign bus_v.req = req & ~sel;
  assign bus_n.req = req & sel;
  assign bus_v.plr = plr;  assign bus_n.plr = plr;
  assign bus_v.ulr = ulr;  assign bus_n.ulr = ulr;
  assign bus_v.llr = llr;  assign bus_n.llr = llr;
  assign bus_v.ccr = ccr;  assign bus_n.ccr = ccr;
  assign bus_v.din = din;  assign bus_n.din = din;
  assign bus_v.ec_in  = ec_in;   assign bus_n.ec_in  = ec_in;
  assign bus_v.err_in = err_in;  assign bus_n.err_in = err_in;

  // observations of one job
  int         obs_exit, obs_start, obs_nwr, obs_ncs_low, obs_viol, obs_busy_bad;
  logic       obs_done;
  logic [1:0] obs_code;
  logic [1:0] obs_wa [8];
  logic [7:0] obs_wd [8];
  logic       obs_post_pulse, obs_post_busy;
  logic [1:0] obs_post_code;

  // expectations of one job
  int         exp_exit, exp_start, exp_nwr, exp_ncs_low;
  logic       exp_done;
  logic [1:0] exp_code;

  // Job timeline from the rules: 1 CHECK, 12 write, 12 read if verifying,
  // 1 ARM, then start; ec d cycles after start, timeout after TO waiting cycles.
  task automatic model_job(input logic v, input logic [7:0] p, u, l, c, input logic e, input int d);
    logic [7:0] want [4];
    bit  mism;
    int  s;
    want = '{p, u, l, c};
    exp_start = 0; exp_nwr = 0; exp_ncs_low = 0; exp_done = 1'b0;
    if (!(l <= p && p <= u)) begin
      exp_code = 2'b01; exp_exit = 2;
      return;
    end
    exp_nwr = 4;
    mism = (corrupt < 4);
    for (int i = 0; i < 4; i++) if (locked && cnt_regs[i] != want[i]) mism = 1'b1;
    s = 1 + 12 + (v ? 12 : 0) + 1 + 1;
    if (v && mism) begin
      exp_code = 2'b10; exp_exit = s - 1;
    end else if (e) begin
      exp_code = 2'b01; exp_exit = s;
    end else begin
      exp_start = s;
      if (d <= TO) begin exp_done = 1'b1; exp_code = 2'b00; exp_exit = s + d + 1; end
      else         begin exp_code = 2'b11; exp_exit = s + TO + 1; end
    end
    exp_ncs_low = exp_exit - 2;
  endtask

  // Issue a job, act as the counter, and record what the sequencer did.
  task automatic drive_job(input logic [7:0] p, u, l, c, input logic e, input int d);
    @(negedge clk);
    plr = p; ulr = u; llr = l; ccr = c; err_in = e; ec_in = 1'b0; req = 1'b1;
    obs_exit = 0; obs_start = 0; obs_nwr = 0; obs_ncs_low = 0; obs_viol = 0; obs_busy_bad = 0;
    obs_done = 1'b0; obs_code = 2'b00;
    @(posedge clk);
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      req = 1'b0;
      ec_in = 1'b0;
      if (!o_nwr && !o_nrd) obs_viol++;
      if (o_den && (o_ncs || !o_nrd)) obs_viol++;
      if (!o_ncs) obs_ncs_low++;
      if (!o_ncs && !o_nwr) begin
        if (obs_nwr < 8) begin obs_wa[obs_nwr] = o_addr; obs_wd[obs_nwr] = o_dout; end
        obs_nwr++;
        if (!locked) cnt_regs[o_addr] = o_dout;
      end
      if (o_start) begin obs_start = n; locked = 1'b1; end
      if (o_done || o_fail) begin
        obs_exit = n; obs_done = o_done; obs_code = o_code;
        if (o_busy || !o_ncs) obs_busy_bad++;
        break;
      end
      if (!o_busy) obs_busy_bad++;
      if (obs_start > 0 && n == obs_start + d) begin ec_in = 1'b1; locked = 1'b0; end
    end
    @(negedge clk);
    ec_in = 1'b0; err_in = 1'b0;
    obs_post_pulse = o_done | o_fail; obs_post_code = o_code; obs_post_busy = o_busy;
  endtask

  // Counter finishes its run while the sequencer is idle.
  task automatic counter_release();
    @(negedge clk); ec_in = 1'b1; locked = 1'b0;
    @(negedge clk); ec_in = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({bus_v.ncs, bus_v.nwr, bus_v.nrd} !== 3'b111) begin errors++;
      $display("FAIL reset_strobes: got %b want 111", {bus_v.ncs, bus_v.nwr, bus_v.nrd}); end
    checks++;
    if ({bus_v.a1, bus_v.a0, bus_v.dout, bus_v.dout_en, bus_v.start_out} !== 12'h000) begin errors++;
      $display("FAIL reset_bus: got %h want 000", {bus_v.a1, bus_v.a0, bus_v.dout, bus_v.dout_en, bus_v.start_out}); end
    checks++;
    if ({bus_v.busy, bus_v.done, bus_v.fail, bus_v.fail_code} !== 5'b0) begin errors++;
      $display("FAIL reset_status: got %b want 00000", {bus_v.busy, bus_v.done, bus_v.fail, bus_v.fail_code}); end
    checks++;
    if ({bus_n.ncs, bus_n.busy, bus_n.dout_en} !== 3'b100) begin errors++;
      $display("FAIL reset_nover: got %b want 100", {bus_n.ncs, bus_n.busy, bus_n.dout_en}); end
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_v.ncs, bus_v.busy} !== 2'b10) begin errors++;
      $display("FAIL reset_idle: got %b want 10", {bus_v.ncs, bus_v.busy}); end
  endtask

  task automatic test_normal();
    sel = 1'b0; counter_release();
    model_job(1'b1, 8'd5, 8'd8, 8'd3, 8'd1, 1'b0, 4);
    drive_job(8'd5, 8'd8, 8'd3, 8'd1, 1'b0, 4);
    checks++;
    if (obs_start !== 27) begin errors++; $display("FAIL normal_start: got %0d want 27", obs_start); end
    checks++;
    if (obs_exit !== exp_exit || obs_done !== 1'b1) begin errors++;
      $display("FAIL normal_done: got cyc %0d done %b want cyc %0d done 1", obs_exit, obs_done, exp_exit); end
    checks++;
    if (obs_nwr !== 4) begin errors++; $display("FAIL normal_nwrites: got %0d want 4", obs_nwr); end
    else for (int i = 0; i < 4; i++) begin
      logic [7:0] w [4];
      w = '{8'h05, 8'h08, 8'h03, 8'h01};
      checks++;
      if (obs_wa[i] !== 2'(i) || obs_wd[i] !== w[i]) begin errors++;
        $display("FAIL normal_write%0d: got %0d:%h want %0d:%h", i, obs_wa[i], obs_wd[i], i, w[i]); end
    end
    checks++;
    if (obs_ncs_low !== exp_ncs_low || obs_viol !== 0 || obs_busy_bad !== 0) begin errors++;
      $display("FAIL normal_bus: got ncs_low %0d viol %0d busy_bad %0d want %0d 0 0",
               obs_ncs_low, obs_viol, obs_busy_bad, exp_ncs_low); end
    checks++;
    if (obs_post_pulse !== 1'b0 || obs_post_code !== 2'b00) begin errors++;
      $display("FAIL normal_post: got pulse %b code %b want 0 00", obs_post_pulse, obs_post_code); end
  endtask

  task automatic test_invalid();
    sel = 1'b0;
    drive_job(8'd2, 8'd8, 8'd3, 8'd1, 1'b0, 4);
    checks++;
    if (obs_exit !== 2 || obs_done !== 1'b0 || obs_code !== 2'b01) begin errors++;
      $display("FAIL invalid_fail: got cyc %0d done %b code %b want 2 0 01", obs_exit, obs_done, obs_code); end
    checks++;
    if (obs_ncs_low !== 0 || obs_nwr !== 0) begin errors++;
      $display("FAIL invalid_bus: got ncs_low %0d writes %0d want 0 0", obs_ncs_low, obs_nwr); end
    checks++;
    if (obs_post_code !== 2'b01 || obs_post_busy !== 1'b0) begin errors++;
      $display("FAIL invalid_hold: got code %b busy %b want 01 0", obs_post_code, obs_post_busy); end
  endtask

  task automatic test_timeout();
    sel = 1'b0; counter_release();
    drive_job(8'd5, 8'd8, 8'd3, 8'd1, 1'b0, TO + 5);
    checks++;
    if (obs_start !== 27 || obs_exit !== 27 + 1 + TO || obs_code !== 2'b11 || obs_done !== 1'b0) begin errors++;
      $display("FAIL timeout: got start %0d exit %0d code %b want 27 %0d 11", obs_start, obs_exit, obs_code, 28 + TO); end
  endtask

  task automatic test_locked();
    sel = 1'b0;
    drive_job(8'd7, 8'd9, 8'd3, 8'd1, 1'b0, 4);
    checks++;
    if (obs_exit !== 26 || obs_code !== 2'b10 || obs_done !== 1'b0) begin errors++;
      $display("FAIL locked_fail: got cyc %0d code %b want 26 10", obs_exit, obs_code); end
    checks++;
    if (obs_start !== 0) begin errors++; $display("FAIL locked_nostart: got %0d want 0", obs_start); end
    counter_release();
  endtask

  task automatic test_ec_at_timeout();
    sel = 1'b0;
    drive_job(8'd5, 8'd8, 8'd3, 8'd2, 1'b0, TO);
    checks++;
    if (obs_exit !== 27 + TO + 1 || obs_done !== 1'b1 || obs_code !== 2'b00) begin errors++;
      $display("FAIL ec_wins: got cyc %0d done %b code %b want %0d 1 00", obs_exit, obs_done, obs_code, 28 + TO); end
  endtask

  task automatic test_ccr_zero_and_err();
    sel = 1'b1;
    drive_job(8'd4, 8'd4, 8'd4, 8'd0, 1'b0, 1);
    checks++;
    if (obs_start !== 15 || obs_exit !== 17 || obs_done !== 1'b1) begin errors++;
      $display("FAIL ccr0: got start %0d exit %0d done %b want 15 17 1", obs_start, obs_exit, obs_done); end
    counter_release();
    drive_job(8'd4, 8'd9, 8'd1, 8'd3, 1'b1, 1);
    checks++;
    if (obs_exit !== 15 || obs_code !== 2'b01 || obs_start !== 0) begin errors++;
      $display("FAIL err_nover: got exit %0d code %b start %0d want 15 01 0", obs_exit, obs_code, obs_start); end
    sel = 1'b0;
    drive_job(8'd4, 8'd9, 8'd1, 8'd3, 1'b1, 1);
    checks++;
    if (obs_exit !== 27 || obs_code !== 2'b01 || obs_start !== 0) begin errors++;
      $display("FAIL err_verify: got exit %0d code %b start %0d want 27 01 0", obs_exit, obs_code, obs_start); end
  endtask

  task automatic test_reset_mid_job();
    int pulses;
    sel = 1'b0;
    @(negedge clk);
    plr = 8'd5; ulr = 8'd8; llr = 8'd3; ccr = 8'd1; req = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 6; n++) begin @(negedge clk); req = 1'b0; end
    checks++;
    if (o_nwr !== 1'b0 || o_addr !== 2'b01 || o_dout !== 8'h08) begin errors++;
      $display("FAIL midreset_strobe: got nwr %b addr %b dout %h want 0 01 08", o_nwr, o_addr, o_dout); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({o_ncs, o_nwr, o_nrd, o_den, o_busy} !== 5'b11100) begin errors++;
      $display("FAIL midreset_release: got %b want 11100", {o_ncs, o_nwr, o_nrd, o_den, o_busy}); end
    pulses = 0;
    repeat (3) begin @(negedge clk); if (o_done || o_fail) pulses++; end
    reset = 1'b1;
    repeat (3) begin @(negedge clk); if (o_done || o_fail) pulses++; end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL midreset_pulse: got %0d want 0", pulses); end
    drive_job(8'd6, 8'd9, 8'd2, 8'd3, 1'b0, 2);
    checks++;
    if (obs_start !== 27 || obs_exit !== 30 || obs_done !== 1'b1) begin errors++;
      $display("FAIL midreset_rerun: got start %0d exit %0d done %b want 27 30 1", obs_start, obs_exit, obs_done); end
  endtask

  task automatic test_random();
    logic [7:0] p, u, l, c, t;
    logic       e;
    int         d;
    for (int it = 0; it < 16; it++) begin
      sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) counter_release();
      if ($urandom_range(0, 3) != 0) begin
        l = 8'($urandom); p = 8'($urandom); u = 8'($urandom);
        if (l > p) begin t = l; l = p; p = t; end
        if (p > u) begin t = p; p = u; u = t; end
        if (l > p) begin t = l; l = p; p = t; end
      end else begin
        l = 8'($urandom_range(1, 255)); p = 8'($urandom_range(0, int'(l) - 1)); u = 8'($urandom);
      end
      c = 8'($urandom);
      e = ($urandom_range(0, 7) == 0);
      d = $urandom_range(1, TO + 2);
      corrupt = (!locked && $urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : 4;
      model_job(~sel, p, u, l, c, e, d);
      drive_job(p, u, l, c, e, d);
      corrupt = 4;
      checks++;
      if (obs_exit !== exp_exit || obs_done !== exp_done || obs_code !== exp_code) begin errors++;
        $display("FAIL rand%0d_outcome: got cyc %0d done %b code %b want %0d %b %b",
                 it, obs_exit, obs_done, obs_code, exp_exit, exp_done, exp_code); end
      checks++;
      if (obs_start !== exp_start || obs_nwr !== exp_nwr || obs_ncs_low !== exp_ncs_low) begin errors++;
        $display("FAIL rand%0d_bus: got start %0d wr %0d ncs_low %0d want %0d %0d %0d",
                 it, obs_start, obs_nwr, obs_ncs_low, exp_start, exp_nwr, exp_ncs_low); end
      checks++;
      if (obs_viol !== 0 || obs_busy_bad !== 0 || obs_post_pulse !== 1'b0 || obs_post_code !== exp_code) begin errors++;
        $display("FAIL rand%0d_proto: got viol %0d busy_bad %0d post %b code %b want 0 0 0 %b",
                 it, obs_viol, obs_busy_bad, obs_post_pulse, obs_post_code, exp_code); end
      if (exp_nwr == 4 && obs_nwr == 4) begin
        checks++;
        if (obs_wd[0] !== p || obs_wd[1] !== u || obs_wd[2] !== l || obs_wd[3] !== c ||
            obs_wa[0] !== 2'd0 || obs_wa[1] !== 2'd1 || obs_wa[2] !== 2'd2 || obs_wa[3] !== 2'd3) begin errors++;
          $display("FAIL rand%0d_writes: got %h %h %h %h want %h %h %h %h",
                   it, obs_wd[0], obs_wd[1], obs_wd[2], obs_wd[3], p, u, l, c); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; sel = 1'b0; req = 1'b0; ec_in = 1'b0; err_in = 1'b0;
    plr = 8'd0; ulr = 8'd0; llr = 8'd0; ccr = 8'd0;
    locked = 1'b0; corrupt = 4;
    for (int i = 0; i < 4; i++) cnt_regs[i] = 8'd0;
    test_reset();
    test_normal();
    test_invalid();
    test_timeout();
    test_locked();
    test_ec_at_timeout();
    test_ccr_zero_and_err();
    test_reset_mid_job();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
